// File: rtl/ctrl_decoder_pkg.sv
// ctrl_decoder_pkg: shared state type, default parameters and width helper for ctrl_decoder_seq
package ctrl_decoder_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  localparam int NUM_CH_DEF = 4;
  localparam int HOLD_CYC_DEF = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/ctrl_decoder_seq_onehot_dec.sv
// onehot_dec: binary channel address to one-hot channel vector
module onehot_dec import ctrl_decoder_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = clog2(NUM_CH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_CH-1:0] onehot
);
  assign onehot = NUM_CH'(1) << addr;
endmodule

// File: rtl/ctrl_decoder_seq.sv
// ctrl_decoder_seq: strobes a burst of consecutive one-hot control channels, each held HOLD_CYC cycles
module ctrl_decoder_seq import ctrl_decoder_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  localparam int ADDR_W = clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              io_REQ_VALID,
  output logic              io_REQ_READY,
  input  logic [ADDR_W-1:0] io_WADD,
  input  logic [7:0]        io_BURST_LEN,
  input  logic              io_ABORT,
  output logic [NUM_CH-1:0] io_CTRL,
  output logic              io_BUSY,
  output logic              io_ERR
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0] rem_q, rem_d, hold_q, hold_d;
  logic [NUM_CH-1:0] ctrl_q, ctrl_d, dec;
  logic err_q, err_d, accept, bad, expire;
  assign io_REQ_READY = state_q == IDLE;
  assign io_BUSY = state_q == ACTIVE;
  assign io_CTRL = ctrl_q;
  assign io_ERR = err_q;
  assign accept = io_REQ_VALID && io_REQ_READY && !io_ABORT;
  assign bad = {1'b0, io_WADD} >= (ADDR_W + 1)'(NUM_CH);
  assign expire = hold_q == 8'd1;
  // explicit compare so non-power-of-two channel counts wrap correctly
  assign addr_nxt = (addr_q == ADDR_W'(NUM_CH - 1)) ? '0 : addr_q + 1'b1;
  onehot_dec #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_dec (.addr(addr_d), .onehot(dec));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (accept && !bad) ? ACTIVE : IDLE;
    else if (io_ABORT || (expire && rem_q <= 8'd1)) state_d = IDLE;
  end
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    hold_d = hold_q;
    err_d  = accept && bad;
    if (accept && !bad) begin
      addr_d = io_WADD;
      rem_d  = (io_BURST_LEN == 8'd0) ? 8'd1 : io_BURST_LEN;
      hold_d = 8'(HOLD_CYC);
    end else if (state_q == ACTIVE) begin
      if (state_d == IDLE) begin
        addr_d = '0;
        rem_d  = '0;
        hold_d = '0;
      end else if (expire) begin
        addr_d = addr_nxt;
        rem_d  = rem_q - 8'd1;
        hold_d = 8'(HOLD_CYC);
      end else hold_d = hold_q - 8'd1;
    end
    ctrl_d = (state_d == ACTIVE) ? dec : '0;
  end
endmodule

// File: tb/tb_ctrl_decoder_seq.sv
// tb_ctrl_decoder_seq: directed checks of ctrl_decoder_seq over several parameter sets
module tb_ctrl_decoder_seq;
  logic clk = 1'b0;
  logic reset_n;
  logic v1, v2, v5, v255, abort;
  logic [2:0] wadd;
  logic [7:0] burst;
  logic r1, r2, r5, r255, b1, b2, b5, b255, e1, e2, e5, e255;
  logic [3:0] c1, c2, c255;
  logic [4:0] c5;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  ctrl_decoder_seq #(.NUM_CH(4), .HOLD_CYC(1)) u1 (.clk(clk), .reset_n(reset_n), .io_REQ_VALID(v1),
    .io_REQ_READY(r1), .io_WADD(wadd[1:0]), .io_BURST_LEN(burst), .io_ABORT(abort), .io_CTRL(c1),
    .io_BUSY(b1), .io_ERR(e1));
  ctrl_decoder_seq #(.NUM_CH(4), .HOLD_CYC(2)) u2 (.clk(clk), .reset_n(reset_n), .io_REQ_VALID(v2),
    .io_REQ_READY(r2), .io_WADD(wadd[1:0]), .io_BURST_LEN(burst), .io_ABORT(abort), .io_CTRL(c2),
    .io_BUSY(b2), .io_ERR(e2));
  ctrl_decoder_seq #(.NUM_CH(5), .HOLD_CYC(1)) u5 (.clk(clk), .reset_n(reset_n), .io_REQ_VALID(v5),
    .io_REQ_READY(r5), .io_WADD(wadd), .io_BURST_LEN(burst), .io_ABORT(abort), .io_CTRL(c5),
    .io_BUSY(b5), .io_ERR(e5));
  ctrl_decoder_seq #(.NUM_CH(4), .HOLD_CYC(255)) u255 (.clk(clk), .reset_n(reset_n), .io_REQ_VALID(v255),
    .io_REQ_READY(r255), .io_WADD(wadd[1:0]), .io_BURST_LEN(burst), .io_ABORT(abort), .io_CTRL(c255),
    .io_BUSY(b255), .io_ERR(e255));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_b [7];
    int n, bad_oh;
    logic [3:0] s1, s255, s256, slast;
    exp_b = '{4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h2, 4'h0};
    reset_n = 1'b0; v1 = 0; v2 = 0; v5 = 0; v255 = 0; abort = 0; wadd = 0; burst = 0;
    #3;
    chk("rst_ctrl", {c1, c2, c5, c255}, 0);
    chk("rst_busy", {b1, b2, b5, b255}, 0);
    chk("rst_err", {e1, e2, e5, e255}, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_ready", {r1, r2, r5, r255}, 4'hf);

    v1 = 1; wadd = 2; burst = 1;
    tick(); v1 = 0;
    chk("a_ctrl", c1, 4'b0100);
    chk("a_busy_ready", {b1, r1}, 2'b10);
    tick();
    chk("a_done_ctrl", c1, 0);
    chk("a_done_busy_ready", {b1, r1}, 2'b01);

    v1 = 1; wadd = 1; burst = 0;
    tick(); v1 = 0;
    chk("len0_ctrl", c1, 4'b0010);
    chk("len0_busy", b1, 1);
    tick();
    chk("len0_done", {c1, b1, r1}, 6'b000001);

    v1 = 1; wadd = 3; burst = 2;
    tick(); v1 = 0;
    chk("wrap4_c0", c1, 4'b1000);
    tick();
    chk("wrap4_c1", c1, 4'b0001);
    tick();
    chk("wrap4_end", {c1, b1}, 0);

    v2 = 1; wadd = 3; burst = 3;
    tick(); wadd = 0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("b_ctrl%0d", i), c2, exp_b[i]);
      chk($sformatf("b_busy%0d", i), b2, (i < 6) ? 1'b1 : 1'b0);
      if (i == 3) v2 = 0;
      tick();
    end
    chk("b_ready", r2, 1);
    tick();
    chk("b_no_late_accept", b2, 0);

    v5 = 1; wadd = 6; burst = 3;
    tick(); v5 = 0;
    chk("err_pulse", e5, 1);
    chk("err_ctrl_busy_ready", {c5, b5, r5}, 7'b0000001);
    tick();
    chk("err_clear", e5, 0);

    v5 = 1; wadd = 4; burst = 2;
    tick(); v5 = 0;
    chk("wrap5_c0", c5, 5'b10000);
    tick();
    chk("wrap5_c1", c5, 5'b00001);
    tick();
    chk("wrap5_end", {c5, b5}, 0);

    v2 = 1; wadd = 0; burst = 4;
    tick(); v2 = 0;
    chk("ab_c1", c2, 4'b0001);
    tick();
    chk("ab_c2", c2, 4'b0001);
    tick();
    chk("ab_c3", c2, 4'b0010);
    abort = 1;
    tick();
    chk("ab_idle", {c2, b2, r2}, 6'b000001);
    v2 = 1; wadd = 1; burst = 1;
    tick();
    chk("ab_req_blocked", {c2, b2, e2}, 0);
    v2 = 0; v5 = 1; wadd = 7;
    tick();
    chk("ab_no_err", {e5, b5}, 0);
    v5 = 0; abort = 0;
    tick();

    v2 = 1; wadd = 1; burst = 3;
    tick(); v2 = 0;
    tick();
    chk("mid_pre", {c2, b2}, 5'b00101);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_async", {c2, b2}, 0);
    #1 reset_n = 1'b1;
    tick();
    chk("mid_no_resume", {c2, b2, r2}, 6'b000001);
    tick();
    chk("mid_still_idle", {c2, b2}, 0);

    v255 = 1; wadd = 0; burst = 255;
    tick(); v255 = 0;
    n = 0; bad_oh = 0; s1 = 0; s255 = 0; s256 = 0; slast = 0;
    while (b255 && n < 70000) begin
      n++;
      if ($countones(c255) != 1) bad_oh++;
      if (n == 1) s1 = c255;
      if (n == 255) s255 = c255;
      if (n == 256) s256 = c255;
      if (n == 65025) slast = c255;
      tick();
    end
    chk("long_cycles", n, 65025);
    chk("long_onehot", bad_oh, 0);
    chk("long_first", s1, 4'b0001);
    chk("long_hold_end", s255, 4'b0001);
    chk("long_next", s256, 4'b0010);
    chk("long_last", slast, 4'b0100);
    chk("long_done", {c255, r255}, 5'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_decoder_seq.md
CTRL_DECODER_SEQ -- requirements
Module: ctrl_decoder_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of one-hot control channels; legal range is 2..64.
REQ-002 SHALL have parameter HOLD_CYC, default 1, giving the cycles each channel stays asserted; legal range is 1..255.
REQ-003 SHALL have parameter ADDR_W, default clog2(NUM_CH), which is derived and not overridable.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port io_REQ_VALID, input, 1 bit: a request is present.
REQ-007 SHALL have port io_REQ_READY, output, 1 bit: the block accepts a request this cycle.
REQ-008 SHALL have port io_WADD, input, ADDR_W bits: start channel address.
REQ-009 SHALL have port io_BURST_LEN, input, 8 bits: number of consecutive channels to strobe; 0 is treated as 1.
REQ-010 SHALL have port io_ABORT, input, 1 bit: synchronous cancel of the current sequence.
REQ-011 SHALL have port io_CTRL, output, NUM_CH bits: registered one-hot control outputs.
REQ-012 SHALL have port io_BUSY, output, 1 bit: a sequence is in progress.
REQ-013 SHALL have port io_ERR, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-014 SHALL implement the states IDLE and ACTIVE.
REQ-015 SHALL drive io_REQ_READY = (state==IDLE) combinationally, with no dependency on io_REQ_VALID.
REQ-016 SHALL accept a request on the rising edge where io_REQ_VALID && io_REQ_READY && !io_ABORT.
REQ-017 SHALL reject an accepted request with io_WADD >= NUM_CH: io_ERR=1 for exactly the next cycle, io_CTRL stays 0, state stays IDLE.
REQ-018 SHALL, for a valid accept at edge k, latch address A, remaining count R=max(io_BURST_LEN,1) and hold counter H=HOLD_CYC, enter ACTIVE, and assert io_CTRL=onehot(A) from cycle k+1.
REQ-019 SHALL keep each channel asserted for exactly HOLD_CYC cycles.
REQ-020 SHALL, when the hold counter expires and R>1, advance A=(A+1) mod NUM_CH and assert the next channel in the immediately following cycle, with no gap cycle and no overlap.
REQ-021 SHALL wrap the address from NUM_CH-1 to 0, including when NUM_CH is not a power of two.
REQ-022 SHALL, when the hold counter expires and R==1, clear io_CTRL and return to IDLE, so io_REQ_READY=1 in the next cycle.
REQ-023 SHALL keep io_CTRL to at most one bit set in every cycle, and io_CTRL==0 in IDLE.
REQ-024 SHALL drive io_BUSY=1 exactly when state==ACTIVE.
REQ-025 SHALL, when io_ABORT=1 at an edge in ACTIVE, clear io_CTRL and enter IDLE at that edge.
REQ-026 SHALL give io_ABORT priority over acceptance at the same edge: the request is not accepted and no io_ERR is raised.
REQ-027 SHALL ignore io_REQ_VALID while in ACTIVE; io_WADD and io_BURST_LEN are sampled only at accept.
REQ-028 SHALL give a total sequence length of max(io_BURST_LEN,1)*HOLD_CYC cycles; a value of 255 with HOLD_CYC=255 SHALL NOT overflow any counter.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously force state=IDLE, io_CTRL=0, io_ERR=0, io_BUSY=0 and all counters to 0, independent of clk.
REQ-030 SHALL, on a reset asserted mid-burst, drop io_CTRL immediately, with no resumption after release.
REQ-031 SHALL drive io_REQ_READY=1 from the first cycle after reset_n deasserts.

Structure
REQ-032 SHALL place the state enum (IDLE, ACTIVE), the clog2 helper and the default parameter constants in the shared package ctrl_decoder_pkg.
REQ-033 SHALL use one combinational sub-module onehot_dec (ADDR_W to NUM_CH binary-to-one-hot), whose output is registered in ctrl_decoder_seq.

Verification
REQ-034 SHALL pass this case with NUM_CH=4, HOLD_CYC=1: reset, then request WADD=2, BURST_LEN=1 -> io_CTRL=0100 for 1 cycle, io_BUSY=1 for that cycle, READY back next cycle.
REQ-035 SHALL pass this case with NUM_CH=4, HOLD_CYC=2: request WADD=3, BURST_LEN=3 -> io_CTRL sequence 1000,1000,0001,0001,0010,0010, then 0000.
REQ-036 SHALL pass this case with NUM_CH=5: request WADD=6 -> io_ERR=1 for one cycle, io_CTRL stays 0, READY stays 1.
REQ-037 SHALL pass this case with NUM_CH=4, HOLD_CYC=2: request WADD=0, BURST_LEN=4, with io_ABORT in the 3rd ACTIVE cycle -> io_CTRL=0 and IDLE at that edge; an abort and a request at the same edge -> not accepted.
REQ-038 SHALL pass this case: reset_n pulsed low mid-burst between clock edges -> io_CTRL=0 and io_BUSY=0 before the next clk edge.
REQ-039 SHALL pass this case: BURST_LEN=0 -> behaves identically to BURST_LEN=1; with HOLD_CYC=255 and BURST_LEN=255 -> exactly 65025 ACTIVE cycles.
